// File: rtl/mesh_router_xy.sv
// Five-port XY-routed mesh router: per-input FIFOs, per-output round-robin
// arbitration and registered outputs. Single-flit packets only.
module mesh_router_xy #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 2,
  parameter int X_W        = 2,
  parameter int Y_W        = 1,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*DATA_WIDTH-1:0] in_data,
  input  logic [4:0]              in_valid,
  output logic [4:0]              in_full_out,
  output logic [5*DATA_WIDTH-1:0] out_data,
  output logic [4:0]              out_valid,
  input  logic [4:0]              out_full_in,
  output logic [15:0]             drop_cnt,
  output logic                    overflow
);

  localparam int NP = 5;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [2:0] P_L = 3'd0;
  localparam logic [2:0] P_N = 3'd1;
  localparam logic [2:0] P_E = 3'd2;
  localparam logic [2:0] P_S = 3'd3;
  localparam logic [2:0] P_W = 3'd4;

  logic [DATA_WIDTH-1:0] mem [NP][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr [NP];
  logic [AW-1:0]         rd_ptr [NP];
  logic [CW-1:0]         count [NP];
  logic [2:0]            rr_ptr [NP];

  logic [DATA_WIDTH-1:0] head [NP];
  logic [2:0]            dir [NP];
  logic [NP-1:0]         full, req, drop, push, pop;
  logic [NP-1:0]         grant_vld;
  logic [2:0]            grant_idx [NP];
  logic [2:0]            drop_n;

  function automatic logic unroutable(input logic [DATA_WIDTH-1:0] flit);
    int dx, dy;
    dx = 0;
    dy = 0;
    dx[X_W-1:0] = flit[DATA_WIDTH-1 -: X_W];
    dy[Y_W-1:0] = flit[DATA_WIDTH-1-X_W -: Y_W];
    return (dx >= MESH_X) || (dy >= MESH_Y);
  endfunction

  // X is resolved first, then Y; a flit already at its column never turns back to X.
  function automatic logic [2:0] route_dir(input logic [DATA_WIDTH-1:0] flit);
    int dx, dy;
    dx = 0;
    dy = 0;
    dx[X_W-1:0] = flit[DATA_WIDTH-1 -: X_W];
    dy[Y_W-1:0] = flit[DATA_WIDTH-1-X_W -: Y_W];
    if (dx > MY_X)      return P_E;
    else if (dx < MY_X) return P_W;
    else if (dy > MY_Y) return P_S;
    else if (dy < MY_Y) return P_N;
    else                return P_L;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      head[p] = mem[p][rd_ptr[p]];
      dir[p]  = route_dir(head[p]);
      full[p] = (count[p] == FULL_CNT);
      req[p]  = (count[p] != '0) && !unroutable(head[p]);
      drop[p] = (count[p] != '0) && unroutable(head[p]);
      push[p] = in_valid[p] && !full[p];
    end
  end

  assign in_full_out = full;

  // Round-robin search per output, starting at rr_ptr and wrapping at port 4.
  always_comb begin
    logic [3:0] cand;
    cand = '0;
    for (int o = 0; o < NP; o++) begin
      grant_vld[o] = 1'b0;
      grant_idx[o] = 3'd0;
      if (!out_full_in[o]) begin
        for (int i = 0; i < NP; i++) begin
          cand = {1'b0, rr_ptr[o]} + 4'(i);
          if (cand >= 4'd5) cand = cand - 4'd5;
          if (!grant_vld[o] && req[cand[2:0]] && dir[cand[2:0]] == 3'(o)) begin
            grant_vld[o] = 1'b1;
            grant_idx[o] = cand[2:0];
          end
        end
      end
    end
  end

  always_comb begin
    drop_n = 3'd0;
    for (int p = 0; p < NP; p++) begin
      pop[p] = drop[p];
      if (drop[p]) drop_n = drop_n + 3'd1;
      for (int o = 0; o < NP; o++) begin
        if (grant_vld[o] && grant_idx[o] == 3'(p)) pop[p] = 1'b1;
      end
    end
  end

  // Flit storage carries no reset; occupancy is tracked by the control registers.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
        rr_ptr[p] <= 3'd0;
      end
      out_valid <= '0;
      out_data  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
        case ({push[p], pop[p]})
          2'b10:   count[p] <= count[p] + CW'(1);
          2'b01:   count[p] <= count[p] - CW'(1);
          default: count[p] <= count[p];
        endcase
      end
      for (int o = 0; o < NP; o++) begin
        out_valid[o] <= grant_vld[o];
        if (grant_vld[o]) begin
          out_data[o*DATA_WIDTH +: DATA_WIDTH] <= head[grant_idx[o]];
          rr_ptr[o] <= (grant_idx[o] == 3'd4) ? 3'd0 : grant_idx[o] + 3'd1;
        end
      end
      drop_cnt <= sat_add(drop_cnt, drop_n);
      if ((in_valid & full) != '0) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mesh_router_xy.sv
// Bench for mesh_router_xy at position (1,1) of a 4x2 mesh with a 3-bit X field,
// using a queue-based reference model plus directed literal expectations.
module tb_mesh_router_xy;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int MX = 4;
  localparam int MY = 2;
  localparam int XW = 3;
  localparam int YW = 1;
  localparam int MYX = 1;
  localparam int MYY = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [5*DW-1:0] in_data;
  logic [4:0]      in_valid;
  logic [4:0]      in_full_out;
  logic [5*DW-1:0] out_data;
  logic [4:0]      out_valid;
  logic [4:0]      out_full_in;
  logic [15:0]     drop_cnt;
  logic            overflow;

  mesh_router_xy #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MESH_X(MX), .MESH_Y(MY),
    .X_W(XW), .Y_W(YW), .MY_X(MYX), .MY_Y(MYY)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_full_out(in_full_out), .out_data(out_data), .out_valid(out_valid),
    .out_full_in(out_full_in), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq [5][$];
  int            rr [5];
  int            mdrop;
  bit            movf;
  logic [4:0]    exp_valid;
  logic [DW-1:0] exp_data [5];

  logic [DW-1:0] got [$];
  int            gcyc [$];
  logic [DW-1:0] e3 [3];

  function automatic logic [DW-1:0] mk(input int x, input int y, input int pl);
    logic [DW-1:0] r;
    r = (x << (DW - XW)) | (y << (DW - XW - YW)) | (pl & 32'h0FFF_FFFF);
    return r;
  endfunction

  // -1 = unroutable, otherwise the output port index.
  function automatic int route_of(input logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f >> (DW - XW));
    dy = int'((f >> (DW - XW - YW)) & ((32'd1 << YW) - 32'd1));
    if (dx >= MX || dy >= MY) return -1;
    if (dx > MYX) return 2;
    if (dx < MYX) return 4;
    if (dy > MYY) return 3;
    if (dy < MYY) return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 5; p++) begin
      mq[p].delete();
      rr[p] = 0;
      exp_data[p] = '0;
    end
    mdrop = 0;
    movf = 1'b0;
    exp_valid = '0;
  endtask

  task automatic model_update();
    int  sz [5];
    bit  popq [5];
    bit  found;
    int  p;
    for (int i = 0; i < 5; i++) begin
      sz[i] = mq[i].size();
      popq[i] = 1'b0;
    end
    exp_valid = '0;
    for (int o = 0; o < 5; o++) begin
      found = 1'b0;
      if (!out_full_in[o]) begin
        for (int i = 0; i < 5; i++) begin
          p = (rr[o] + i) % 5;
          if (!found && sz[p] > 0 && route_of(mq[p][0]) == o) begin
            found = 1'b1;
            exp_valid[o] = 1'b1;
            exp_data[o] = mq[p][0];
            popq[p] = 1'b1;
            rr[o] = (p + 1) % 5;
          end
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (sz[i] > 0 && route_of(mq[i][0]) < 0) begin
        popq[i] = 1'b1;
        if (mdrop < 65535) mdrop++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (popq[i]) void'(mq[i].pop_front());
      if (in_valid[i]) begin
        if (sz[i] < DEPTH) mq[i].push_back(in_data[i*DW +: DW]);
        else movf = 1'b1;
      end
    end
  endtask

  task automatic compare();
    logic [4:0] efull;
    chk("out_valid", out_valid, exp_valid);
    for (int o = 0; o < 5; o++) begin
      if (exp_valid[o]) chk("out_data", out_data[o*DW +: DW], exp_data[o]);
      efull[o] = (mq[o].size() == DEPTH);
    end
    chk("in_full_out", in_full_out, efull);
    chk("drop_cnt", drop_cnt, 16'(mdrop));
    chk("overflow", overflow, movf);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    in_valid = '0;
    in_data = '0;
  endtask

  task automatic collect(input int port, input int n);
    got.delete();
    gcyc.delete();
    for (int i = 0; i < n; i++) begin
      step();
      if (out_valid[port]) begin
        got.push_back(out_data[port*DW +: DW]);
        gcyc.push_back(i);
      end
    end
  endtask

  task automatic chk_order(input string nm);
    chk({nm, "_count"}, got.size(), 3);
    for (int i = 0; i < 3; i++) chk(nm, (i < got.size()) ? got[i] : 'x, e3[i]);
    if (gcyc.size() == 3) chk({nm, "_b2b"}, gcyc[2] - gcyc[0], 2);
  endtask

  int run, maxrun, stale;
  bit fullseen;

  initial begin
    rst = 1'b1;
    idle();
    out_full_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 5'd0);
    chk("rst_out_data", out_data[63:0], 64'd0);
    chk("rst_in_full", in_full_out, 5'd0);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_ovf", overflow, 1'b0);
    rst = 1'b0;

    // Uncontended Local -> East
    in_data[0 +: DW] = mk(3, 1, 'hABCDE);
    in_valid = 5'b00001;
    step();
    idle();
    step();
    chk("t1_valid", out_valid, 5'b00100);
    chk("t1_data", out_data[2*DW +: DW], 32'h700A_BCDE);
    step();

    // Round-robin into Local from ptr 0
    in_data[1*DW +: DW] = mk(1, 1, 'h111);
    in_data[3*DW +: DW] = mk(1, 1, 'h333);
    in_data[4*DW +: DW] = mk(1, 1, 'h444);
    in_valid = 5'b11010;
    step();
    idle();
    collect(0, 5);
    e3 = '{32'h3000_0111, 32'h3000_0333, 32'h3000_0444};
    chk_order("t2_ptr0");

    // Move Local pointer to 4 by a lone grant from S
    in_data[3*DW +: DW] = mk(1, 1, 'h555);
    in_valid = 5'b01000;
    step();
    idle();
    step();
    chk("t2_single", out_data[0 +: DW], 32'h3000_0555);
    step();
    in_data[1*DW +: DW] = mk(1, 1, 'h121);
    in_data[3*DW +: DW] = mk(1, 1, 'h323);
    in_data[4*DW +: DW] = mk(1, 1, 'h424);
    in_valid = 5'b11010;
    step();
    idle();
    collect(0, 5);
    e3 = '{32'h3000_0424, 32'h3000_0121, 32'h3000_0323};
    chk_order("t2_ptr4");

    // Backpressure on East, overflow on the fifth write
    out_full_in = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      idle();
      in_data[0 +: DW] = mk(3, 1, 'h301 + i);
      in_valid = 5'b00001;
      step();
      if (i == 3) chk("t3_full", in_full_out[0], 1'b1);
    end
    chk("t3_ovf", overflow, 1'b1);
    idle();
    out_full_in = '0;
    got.delete();
    gcyc.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid[2]) begin
        got.push_back(out_data[2*DW +: DW]);
        gcyc.push_back(i);
      end
    end
    chk("t3_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", (i < got.size()) ? got[i] : 'x, 32'h7000_0301 + i);
    if (gcyc.size() == 4) chk("t3_b2b", gcyc[3] - gcyc[0], 3);

    // Unroutable flit
    in_data[0 +: DW] = mk(5, 0, 'h44);
    in_valid = 5'b00001;
    step();
    idle();
    step();
    step();
    chk("t4_drop", drop_cnt, 16'd1);
    chk("t4_no_out", out_valid, 5'd0);
    in_data[0 +: DW] = mk(3, 0, 'h45);
    in_valid = 5'b00001;
    step();
    idle();
    step();
    chk("t4_after", out_valid, 5'b00100);

    // Streaming 100 flits Local -> East
    run = 0;
    maxrun = 0;
    fullseen = 1'b0;
    for (int i = 0; i < 104; i++) begin
      idle();
      if (i < 100) begin
        in_data[0 +: DW] = mk(3, 1, i);
        in_valid = 5'b00001;
      end
      step();
      if (out_valid[2]) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
      if (in_full_out[0]) fullseen = 1'b1;
    end
    chk("t6_run", maxrun, 100);
    chk("t6_full", fullseen, 1'b0);

    // Reset with flits buffered in West and an output in flight
    idle();
    out_full_in = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      in_data[4*DW +: DW] = mk(3, 0, 'h500 + i);
      in_valid = 5'b10000;
      step();
    end
    idle();
    in_data[0 +: DW] = mk(1, 1, 'h5A);
    in_valid = 5'b00001;
    step();
    idle();
    step();
    chk("t5_pre_valid", out_valid[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 5'd0);
    chk("t5_rst_full", in_full_out, 5'd0);
    chk("t5_rst_data", out_data[63:0], 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_full_in = '0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid != '0) stale++;
    end
    chk("t5_stale", stale, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
